// File: rtl/present_pkg.sv
// Shared PRESENT definitions: key sizes, schedule length, S-boxes and the
// key-unroll FSM state encoding.
package present_pkg;

  localparam int unsigned KEY_BITS_80  = 80;
  localparam int unsigned KEY_BITS_128 = 128;
  localparam int unsigned NUM_ROUNDS   = 31;
  localparam int unsigned RK_BITS      = 64;
  localparam int unsigned CTR_BITS     = 5;
  localparam int unsigned IDX_BITS     = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_EMIT = 2'd2
  } state_e;

  typedef enum logic {
    DIR_FWD = 1'b0,
    DIR_INV = 1'b1
  } dir_e;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
      4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
      4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
      4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/present_key_step.sv
// One PRESENT key-schedule update, forward (as in the encrypt scheduler) or
// its exact inverse, selected by dir_i.
module present_key_step
  import present_pkg::*;
#(
  parameter int unsigned KEY_BITS = KEY_BITS_80
) (
  input  logic                dir_i,
  input  logic [KEY_BITS-1:0] key_i,
  input  logic [CTR_BITS-1:0] ctr_i,
  output logic [KEY_BITS-1:0] key_o
);

  localparam bit          WIDE    = (KEY_BITS == KEY_BITS_128);
  localparam int unsigned CTR_LSB = WIDE ? 62 : 15;

  logic [KEY_BITS-1:0] fwd_rot;
  logic [KEY_BITS-1:0] fwd_key;
  logic [KEY_BITS-1:0] inv_mix;
  logic [KEY_BITS-1:0] inv_key;

  // Forward: rotate, substitute top nibble(s), fold in counter.
  // Inverse undoes the same three steps in reverse order.
  always_comb begin
    fwd_rot = {key_i[KEY_BITS-62:0], key_i[KEY_BITS-1:KEY_BITS-61]};
    fwd_key = fwd_rot;
    fwd_key[KEY_BITS-1 -: 4] = sbox(fwd_rot[KEY_BITS-1 -: 4]);
    if (WIDE) begin
      fwd_key[KEY_BITS-5 -: 4] = sbox(fwd_rot[KEY_BITS-5 -: 4]);
    end
    fwd_key[CTR_LSB +: CTR_BITS] = fwd_rot[CTR_LSB +: CTR_BITS] ^ ctr_i;

    inv_mix = key_i;
    inv_mix[CTR_LSB +: CTR_BITS] = key_i[CTR_LSB +: CTR_BITS] ^ ctr_i;
    inv_mix[KEY_BITS-1 -: 4] = sbox_inv(key_i[KEY_BITS-1 -: 4]);
    if (WIDE) begin
      inv_mix[KEY_BITS-5 -: 4] = sbox_inv(key_i[KEY_BITS-5 -: 4]);
    end
    inv_key = {inv_mix[60:0], inv_mix[KEY_BITS-1:61]};

    key_o = (dir_i == DIR_INV) ? inv_key : fwd_key;
  end

endmodule

// File: rtl/present_key_unroll.sv
// Decrypt-side PRESENT key scheduler: runs the schedule forward to the last
// key state, then walks it backwards streaming round keys 32 down to 1.
module present_key_unroll #(
  parameter int unsigned KEY_BITS   = present_pkg::KEY_BITS_80,
  parameter int unsigned NUM_ROUNDS = present_pkg::NUM_ROUNDS
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [KEY_BITS-1:0]                  key_in,
  output logic                                 busy,
  output logic                                 rk_valid,
  input  logic                                 rk_ready,
  output logic [present_pkg::RK_BITS-1:0]      rk,
  output logic [present_pkg::IDX_BITS-1:0]     rk_idx,
  output logic                                 done
);

  import present_pkg::*;

  if ((KEY_BITS != KEY_BITS_80) && (KEY_BITS != KEY_BITS_128)) begin : g_bad_key_bits
    $error("present_key_unroll: KEY_BITS must be 80 or 128");
  end
  if ((NUM_ROUNDS < 1) || (NUM_ROUNDS > 31)) begin : g_bad_rounds
    $error("present_key_unroll: NUM_ROUNDS must be 1..31");
  end

  localparam logic [CTR_BITS-1:0] LAST_CTR  = CTR_BITS'(NUM_ROUNDS);
  localparam logic [IDX_BITS-1:0] FIRST_IDX = IDX_BITS'(NUM_ROUNDS + 1);
  localparam logic [IDX_BITS-1:0] IDX_ONE   = IDX_BITS'(1);

  state_e              state_q, state_d;
  logic [KEY_BITS-1:0] key_q, key_d, step_key;
  logic [CTR_BITS-1:0] ctr_q, ctr_d, step_ctr;
  logic [IDX_BITS-1:0] rk_idx_q, rk_idx_d;
  logic                busy_q, busy_d;
  logic                rk_valid_q, rk_valid_d;
  logic                done_q, done_d;
  logic                step_dir;
  logic                handshake;
  logic                last_key;

  assign handshake = rk_valid_q && rk_ready;
  assign last_key  = (rk_idx_q == IDX_ONE);
  assign step_dir  = (state_q == ST_EMIT) ? DIR_INV : DIR_FWD;
  // Going backwards from key r, the update to undo used counter r-1.
  assign step_ctr  = (state_q == ST_EMIT) ? CTR_BITS'(rk_idx_q - IDX_ONE) : ctr_q;

  present_key_step #(
    .KEY_BITS(KEY_BITS)
  ) u_step (
    .dir_i (step_dir),
    .key_i (key_q),
    .ctr_i (step_ctr),
    .key_o (step_key)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    ctr_d    = ctr_q;
    rk_idx_d = rk_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          key_d   = key_in;
          ctr_d   = CTR_BITS'(1);
          state_d = ST_FWD;
        end
      end
      ST_FWD: begin
        key_d = step_key;
        ctr_d = ctr_q + CTR_BITS'(1);
        if (ctr_q == LAST_CTR) begin
          ctr_d    = '0;
          rk_idx_d = FIRST_IDX;
          state_d  = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (handshake) begin
          if (last_key) begin
            key_d    = '0;
            rk_idx_d = '0;
            state_d  = ST_IDLE;
          end else begin
            key_d    = step_key;
            rk_idx_d = rk_idx_q - IDX_ONE;
          end
        end
      end
      default: begin
        key_d    = '0;
        ctr_d    = '0;
        rk_idx_d = '0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // Output decode, registered below.
  always_comb begin
    busy_d     = (state_d != ST_IDLE);
    rk_valid_d = (state_d == ST_EMIT);
    done_d     = (state_q == ST_EMIT) && handshake && last_key;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q      <= '0;
      ctr_q      <= '0;
      rk_idx_q   <= '0;
      busy_q     <= 1'b0;
      rk_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      key_q      <= key_d;
      ctr_q      <= ctr_d;
      rk_idx_q   <= rk_idx_d;
      busy_q     <= busy_d;
      rk_valid_q <= rk_valid_d;
      done_q     <= done_d;
    end
  end

  assign busy     = busy_q;
  assign rk_valid = rk_valid_q;
  assign rk       = key_q[KEY_BITS-1 -: RK_BITS];
  assign rk_idx   = rk_idx_q;
  assign done     = done_q;

endmodule

// File: tb/tb_present_key_unroll.sv
// Scoreboard bench for present_key_unroll: 80- and 128-bit instances checked
// against a forward-schedule model, reversed.
module tb_present_key_unroll;

  localparam logic [3:0] SBOX [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                       4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
  localparam logic [63:0] RK32_ZERO = 64'h6dab31744f41d700;
  localparam logic [63:0] RK2_ZERO  = 64'hc000000000000000;

  typedef struct packed {
    logic        inst;
    logic [5:0]  idx;
    logic [63:0] rk;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start_s [2];
  logic [79:0]  key80;
  logic [127:0] key128;
  logic         rdy = 1'b1;
  logic         busy_s  [2];
  logic         valid_s [2];
  logic         done_s  [2];
  logic [63:0]  rk_s    [2];
  logic [5:0]   idx_s   [2];

  exp_t         sb [$];
  bit           hold     [2];
  logic [63:0]  hold_rk  [2];
  logic [5:0]   hold_idx [2];
  bit           done_exp [2];
  bit           bp_en;
  int           passed;
  int           total;

  present_key_unroll #(.KEY_BITS(80), .NUM_ROUNDS(31)) u_dut80 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .key_in(key80),
    .busy(busy_s[0]), .rk_valid(valid_s[0]), .rk_ready(rdy),
    .rk(rk_s[0]), .rk_idx(idx_s[0]), .done(done_s[0])
  );

  present_key_unroll #(.KEY_BITS(128), .NUM_ROUNDS(31)) u_dut128 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .key_in(key128),
    .busy(busy_s[1]), .rk_valid(valid_s[1]), .rk_ready(rdy),
    .rk(rk_s[1]), .rk_idx(idx_s[1]), .done(done_s[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string nm, input logic [71:0] act, input logic [71:0] want);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %h want %h (t=%0t)", nm, act, want, $time);
  endtask

  function automatic logic [127:0] fwd_step(input logic [127:0] k, input bit wide, input logic [4:0] c);
    logic [127:0] t;
    t = '0;
    if (wide) begin
      t = {k[66:0], k[127:67]};
      t[127:124] = SBOX[t[127:124]];
      t[123:120] = SBOX[t[123:120]];
      t[66:62]   = t[66:62] ^ c;
    end else begin
      t[79:0]  = {k[18:0], k[79:19]};
      t[79:76] = SBOX[t[79:76]];
      t[19:15] = t[19:15] ^ c;
    end
    return t;
  endfunction

  // Expected stream: forward round keys, pushed in reverse (32 down to 1).
  task automatic push_run(input bit inst, input logic [127:0] key, input bit zero_vec);
    logic [127:0] ks [32];
    exp_t e;
    ks[0] = key;
    for (int i = 1; i < 32; i++) ks[i] = fwd_step(ks[i-1], inst, 5'(i));
    for (int r = 32; r >= 1; r--) begin
      e.inst = inst;
      e.idx  = 6'(r);
      e.rk   = inst ? ks[r-1][127:64] : ks[r-1][79:16];
      if (zero_vec) begin
        if (r == 32)     e.rk = RK32_ZERO;
        else if (r == 2) e.rk = RK2_ZERO;
        else if (r == 1) e.rk = 64'h0;
      end
      sb.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input bit inst, input logic [127:0] key);
    if (inst) key128 = key;
    else      key80  = key[79:0];
    start_s[inst] = 1'b1;
    tick();
    start_s[inst] = 1'b0;
  endtask

  task automatic wait_valid(input bit inst, output int edges);
    edges = 0;
    while (!valid_s[inst] && edges < 100) begin tick(); edges++; end
    if (!valid_s[inst]) chk(1'b0, "valid_timeout", 72'(0), 72'(1));
  endtask

  task automatic wait_done(input bit inst, output int edges);
    edges = 0;
    while (!done_s[inst] && edges < 400) begin tick(); edges++; end
    if (!done_s[inst]) chk(1'b0, "done_timeout", 72'(0), 72'(1));
  endtask

  task automatic run(input bit inst, input logic [127:0] key, input bit zero_vec);
    int e1, e2;
    push_run(inst, key, zero_vec);
    do_start(inst, key);
    wait_valid(inst, e1);
    chk(e1 == 31, "valid_latency", 72'(e1), 72'(31));
    wait_done(inst, e2);
    if (!bp_en) chk(1 + e1 + e2 == 64, "start_to_done", 72'(1 + e1 + e2), 72'(64));
  endtask

  task automatic check_idle_outputs(input bit inst, input string nm);
    chk(busy_s[inst] == 1'b0, {nm, "_busy"}, 72'(busy_s[inst]), 72'(0));
    chk(valid_s[inst] == 1'b0, {nm, "_rk_valid"}, 72'(valid_s[inst]), 72'(0));
    chk(rk_s[inst] == 64'h0, {nm, "_rk"}, 72'(rk_s[inst]), 72'(0));
    chk(idx_s[inst] == 6'h0, {nm, "_rk_idx"}, 72'(idx_s[inst]), 72'(0));
    chk(done_s[inst] == 1'b0, {nm, "_done"}, 72'(done_s[inst]), 72'(0));
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1 check_idle_outputs(1'b0, "rst_async80");
    check_idle_outputs(1'b1, "rst_async128");
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    tick();
  endtask

  always @(posedge clk) begin
    #1;
    rdy = bp_en ? ($urandom_range(0, 99) >= 40) : 1'b1;
  end

  // Monitor: pops the scoreboard on each handshake, checks stall stability
  // and that done pulses only right after the idx-1 handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      for (int n = 0; n < 2; n++) begin
        hold[n] = 1'b0;
        done_exp[n] = 1'b0;
      end
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (done_s[n] || done_exp[n])
          chk(done_s[n] == done_exp[n], "done_pulse", 72'(done_s[n]), 72'(done_exp[n]));
        done_exp[n] = 1'b0;
        if (hold[n])
          chk(valid_s[n] && rk_s[n] == hold_rk[n] && idx_s[n] == hold_idx[n], "stall_stable",
              {1'b0, valid_s[n], idx_s[n], rk_s[n]}, {2'b01, hold_idx[n], hold_rk[n]});
        if (valid_s[n] && rdy) begin
          hold[n] = 1'b0;
          if (sb.size() == 0) begin
            chk(1'b0, "unexpected_key", {2'b0, idx_s[n], rk_s[n]}, 72'(0));
          end else begin
            e = sb.pop_front();
            chk(e.inst == 1'(n) && e.idx == idx_s[n] && e.rk == rk_s[n], "round_key",
                {1'(n), 1'b0, idx_s[n], rk_s[n]}, {e.inst, 1'b0, e.idx, e.rk});
            if (e.idx == 6'd1) done_exp[n] = 1'b1;
          end
        end else if (valid_s[n]) begin
          hold[n]     = 1'b1;
          hold_rk[n]  = rk_s[n];
          hold_idx[n] = idx_s[n];
        end else begin
          hold[n] = 1'b0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] k;
    int e1, e2;
    passed = 0;
    total  = 0;
    bp_en  = 1'b0;
    rst_n  = 1'b0;
    start_s[0] = 1'b0;
    start_s[1] = 1'b0;
    key80  = '0;
    key128 = '0;
    repeat (2) @(negedge clk);
    check_idle_outputs(1'b0, "reset80");
    check_idle_outputs(1'b1, "reset128");
    #2 rst_n = 1'b1;
    tick();

    // All-zero 80-bit key with hand-computed first/last round keys.
    run(1'b0, 128'h0, 1'b1);
    tick();

    // Golden comparison, no backpressure.
    for (int i = 0; i < 5; i++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      k[127:80] = '0;
      run(1'b0, k, 1'b0);
      k = {$urandom, $urandom, $urandom, $urandom};
      run(1'b1, k, 1'b0);
    end

    // Random backpressure.
    bp_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      k[127:80] = '0;
      run(1'b0, k, 1'b0);
      k = {$urandom, $urandom, $urandom, $urandom};
      run(1'b1, k, 1'b0);
    end
    bp_en = 1'b0;
    tick();

    // Reset during FWD, then a clean run.
    k = 128'h0000_0000_0000_0000_0123_4567_89ab_cdef;
    push_run(1'b0, k, 1'b0);
    do_start(1'b0, k);
    repeat (10) tick();
    pulse_reset();
    k = 128'h0000_0000_0000_ffee_ddcc_bbaa_9988_7766;
    run(1'b0, k, 1'b0);

    // Reset in EMIT at idx 17, then a clean run.
    k = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    push_run(1'b1, k, 1'b0);
    do_start(1'b1, k);
    e1 = 0;
    while (idx_s[1] != 6'd17 && e1 < 100) begin tick(); e1++; end
    chk(idx_s[1] == 6'd17, "reach_idx17", 72'(idx_s[1]), 72'(17));
    pulse_reset();
    run(1'b1, k, 1'b0);

    // Stray starts in FWD and EMIT are ignored.
    k = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    push_run(1'b1, k, 1'b0);
    do_start(1'b1, k);
    repeat (5) tick();
    start_s[1] = 1'b1;
    key128 = ~k;
    tick();
    start_s[1] = 1'b0;
    wait_valid(1'b1, e1);
    repeat (3) tick();
    start_s[1] = 1'b1;
    tick();
    start_s[1] = 1'b0;
    wait_done(1'b1, e2);

    // Start accepted in the done cycle: back-to-back run.
    k = 128'h9999_aaaa_bbbb_cccc_dddd_eeee_ffff_0000;
    push_run(1'b1, k, 1'b0);
    do_start(1'b1, k);
    wait_valid(1'b1, e1);
    chk(e1 == 31, "b2b_valid_latency", 72'(e1), 72'(31));
    wait_done(1'b1, e2);

    repeat (4) tick();
    chk(sb.size() == 0, "scoreboard_drained", 72'(sb.size()), 72'(0));
    check_idle_outputs(1'b0, "final80");
    check_idle_outputs(1'b1, "final128");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
